branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Sequencing controller for control-transfer instructions in the RV32I core. It sits between decode and fetch, and accepts one branch or jump request at a time through a valid/ready handshake. It drives the core's `branch` comparator, computes the target and link address, and checks target alignment. For taken transfers it issues a PC redirect and then a fixed-length pipeline flush; it stalls further requests until the whole sequence completes.

## Interface
Parameters:
- FLUSH_CYCLES, 2, number of cycles `flush` stays high after a redirect handshake. Legal range 1..15.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; rising edge active
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  controller can accept a request
- req_kind  in  2  00 conditional branch, 01 jal, 10 jalr, 11 reserved
- req_funct3  in  3  branch condition code, RV32I B-type encoding
- req_rs1, req_rs2  in  32  operand values
- req_pc  in  32  PC of the instruction
- req_imm  in  32  sign-extended immediate
- done_valid  out  1  one-cycle completion pulse
- done_taken  out  1  transfer taken; qualified by done_valid
- link_data  out  32  req_pc+4 for jal/jalr; 0 otherwise; qualified by done_valid
- misalign  out  1  target[1] set on a taken transfer; qualified by done_valid
- redirect_valid  out  1  new PC offered to fetch
- redirect_ready  in  1  fetch accepts the redirect
- redirect_pc  out  32  target address
- flush  out  1  kill younger in-flight instructions
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, EVAL, REDIRECT, FLUSH.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields and go to EVAL.
- EVAL:
  - The latched operands feed the `branch` comparator with en=1 only when kind=00. Taken is the comparator output for kind=00, 1 for jal/jalr, and 0 for kind=11.
  - Undefined funct3 (010, 011) gives not-taken.
  - Target for branch/jal is pc+imm; for jalr it is (rs1+imm) & ~1. All additions are modulo 2^32, and wrap-around is silent.
  - Result (done_taken, link_data, misalign) is registered at the end of EVAL. Always go to REDIRECT.
- REDIRECT:
  - done_valid pulses high in the first cycle of this state only.
  - If not taken, or if misalign: no redirect, return to IDLE next cycle.
  - Otherwise hold redirect_valid=1 and redirect_pc stable until redirect_ready. Take the handshake in the same cycle, then go to FLUSH.
  - redirect_ready may already be high in the first cycle; the handshake then completes in that cycle.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES cycles, using a 4-bit down-counter.
  - Go to IDLE after the last flush cycle.
- req_ready=0 in every state except IDLE.
- Reset, including mid-operation: state goes to IDLE; all outputs are 0 except req_ready=1; latched fields and counters clear.

## Timing
- Request accepted in cycle T.
- Decision fixed at T+1 (EVAL); done_valid at T+2.
- Not-taken path: req_ready=1 again at T+3.
- Taken path, redirect_ready high at T+2: flush high T+3..T+2+FLUSH_CYCLES, req_ready at T+3+FLUSH_CYCLES.
- Each cycle of redirect_ready=0 adds one cycle to the taken path.
- redirect_valid never drops before the handshake completes.
- flush is never high in the same cycle as redirect_valid.
- All outputs are registered; none depends combinationally on the req_* inputs.

## Configuration
- Macro: BRANCH_CTRL_STATS_EN.
- Defined: adds input stat_clr (1 bit) and outputs stat_total and stat_taken (32 bits each).
  - stat_total increments on every done_valid.
  - stat_taken increments on done_valid with done_taken=1.
  - Both counters wrap at 2^32, are cleared by rst, and are cleared synchronously by stat_clr. If stat_clr coincides with an increment, the clear wins.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `branch_ctrl_pkg` holds:
  - the state enum;
  - req_kind encodings KIND_BR, KIND_JAL, KIND_JALR;
  - funct3 constants for beq, bne, blt, bge, bltu, bgeu.
- Single sub-module: the existing `branch` comparator, instantiated once. The target adder, FSM and flush counter stay inline.

## Test plan
- beq, rs1=rs2=0x5, pc=0x100, imm=0x20 -> done_taken=1 at T+2; redirect_pc=0x120; flush high for 2 cycles; req_ready back at T+5.
- bltu, rs1=0xFFFFFFFF, rs2=0x1 -> done_taken=0, no redirect, no flush, req_ready at T+3. Same operands with blt -> taken.
- jalr, rs1=0x1003, imm=0, pc=0x40 -> redirect_pc=0x1002, link_data=0x44, misalign=1, no redirect, no flush.
- jal, pc=0xFFFFFFF0, imm=0x20 -> redirect_pc=0x10 (wrap); redirect_ready held low 3 cycles -> redirect_valid stable 4 cycles, then flush; req_valid held high throughout is not accepted until IDLE.
- rst asserted during FLUSH -> flush, busy and redirect_valid go low immediately; req_ready=1; the next request is processed normally.
- With BRANCH_CTRL_STATS_EN: 3 taken and 2 not-taken requests -> stat_total=5, stat_taken=3; stat_clr coinciding with a done_valid -> both counters 0.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch/jump sequencing controller.
// Holds FSM state codes, request-kind encodings and B-type funct3 codes.
// Imported by branch_ctrl and its comparator sub-module.
package branch_ctrl_pkg;

  // FSM state codes, kept as plain constants for legacy tool compatibility
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_EVAL     = 2'd1;
  localparam state_t ST_REDIRECT = 2'd2;
  localparam state_t ST_FLUSH    = 2'd3;

  // req_kind encodings (2'b11 is reserved and never taken)
  localparam logic [1:0] KIND_BR   = 2'b00;
  localparam logic [1:0] KIND_JAL  = 2'b01;
  localparam logic [1:0] KIND_JALR = 2'b10;

  // RV32I B-type condition codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_ctrl_branch.sv
// Branch condition comparator for RV32I B-type instructions.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Undefined funct3 codes and en=0 both yield not-taken.
module branch
  import branch_ctrl_pkg::*;
(
  input  logic        en,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        taken
);

  // Evaluate the selected condition; everything else is not-taken
  always_comb begin
    taken = 1'b0;
    if (en) begin
      case (funct3)
        F3_BEQ:  taken = (rs1 == rs2);
        F3_BNE:  taken = (rs1 != rs2);
        F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
        F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
        F3_BLTU: taken = (rs1 <  rs2);
        F3_BGEU: taken = (rs1 >= rs2);
        default: taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Control-transfer sequencer: accept request, evaluate, redirect fetch, flush.
// Latency: done_valid 2 cycles after accept; taken path adds redirect wait + FLUSH_CYCLES.
// Backpressure: req_ready only in IDLE; redirect held until redirect_ready.
// Optional macro BRANCH_CTRL_STATS_EN adds stat_clr/stat_total/stat_taken counters.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_imm,
  output logic        done_valid,
  output logic        done_taken,
  output logic [31:0] link_data,
  output logic        misalign,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic        flush,
`ifdef BRANCH_CTRL_STATS_EN
  input  logic        stat_clr,
  output logic [31:0] stat_total,
  output logic [31:0] stat_taken,
`endif
  output logic        busy
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t      state;
  logic [1:0]  lat_kind;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_rs1, lat_rs2, lat_pc, lat_imm;
  logic [3:0]  flush_cnt;

  logic        cmp_taken;
  logic        eval_taken;
  logic [31:0] eval_target;
  logic [31:0] eval_link;
  logic        eval_mis;

  branch u_branch (
    .en     (lat_kind == KIND_BR),
    .funct3 (lat_funct3),
    .rs1    (lat_rs1),
    .rs2    (lat_rs2),
    .taken  (cmp_taken)
  );

  // Decision, target and link address from the latched request
  always_comb begin
    eval_taken  = 1'b0;
    eval_target = lat_pc + lat_imm;
    eval_link   = 32'd0;
    case (lat_kind)
      KIND_BR:  eval_taken = cmp_taken;
      KIND_JAL: begin
        eval_taken = 1'b1;
        eval_link  = lat_pc + 32'd4;
      end
      KIND_JALR: begin
        eval_taken  = 1'b1;
        eval_target = (lat_rs1 + lat_imm) & ~32'd1;
        eval_link   = lat_pc + 32'd4;
      end
      default: eval_taken = 1'b0;
    endcase
    eval_mis = eval_taken & eval_target[1];
  end

  // FSM with fully registered outputs; redirect_valid doubles as "redirect owed"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      req_ready      <= 1'b1;
      busy           <= 1'b0;
      lat_kind       <= 2'd0;
      lat_funct3     <= 3'd0;
      lat_rs1        <= 32'd0;
      lat_rs2        <= 32'd0;
      lat_pc         <= 32'd0;
      lat_imm        <= 32'd0;
      done_valid     <= 1'b0;
      done_taken     <= 1'b0;
      link_data      <= 32'd0;
      misalign       <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      flush          <= 1'b0;
      flush_cnt      <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_kind   <= req_kind;
            lat_funct3 <= req_funct3;
            lat_rs1    <= req_rs1;
            lat_rs2    <= req_rs2;
            lat_pc     <= req_pc;
            lat_imm    <= req_imm;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          done_valid     <= 1'b1;
          done_taken     <= eval_taken;
          link_data      <= eval_link;
          misalign       <= eval_mis;
          redirect_pc    <= eval_target;
          redirect_valid <= eval_taken & ~eval_mis;
          state          <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          done_valid <= 1'b0;
          if (!redirect_valid) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else if (redirect_ready) begin
            redirect_valid <= 1'b0;
            flush          <= 1'b1;
            flush_cnt      <= FLUSH_INIT;
            state          <= ST_FLUSH;
          end
        end
        default: begin
          if (flush_cnt <= 4'd1) begin
            flush     <= 1'b0;
            flush_cnt <= 4'd0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
      endcase
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  // Completion counters; a coincident clear beats the increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_total <= 32'd0;
      stat_taken <= 32'd0;
    end else if (stat_clr) begin
      stat_total <= 32'd0;
      stat_taken <= 32'd0;
    end else if (done_valid) begin
      stat_total <= stat_total + 32'd1;
      if (done_taken) stat_taken <= stat_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl (FLUSH_CYCLES=2).
// Samples outputs 1ns after the rising edge and drives inputs there too.
// Stat counter checks are compiled only with BRANCH_CTRL_STATS_EN.
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_kind;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1, req_rs2, req_pc, req_imm;
  logic        done_valid, done_taken, misalign;
  logic [31:0] link_data, redirect_pc;
  logic        redirect_valid, redirect_ready, flush, busy;
`ifdef BRANCH_CTRL_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_total, stat_taken;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_pc(req_pc), .req_imm(req_imm),
    .done_valid(done_valid), .done_taken(done_taken), .link_data(link_data),
    .misalign(misalign), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .flush(flush),
`ifdef BRANCH_CTRL_STATS_EN
    .stat_clr(stat_clr), .stat_total(stat_total), .stat_taken(stat_taken),
`endif
    .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one request for a single cycle; returns at T+2 (done_valid cycle)
  task automatic issue(input logic [1:0] kind, input logic [2:0] f3,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] pc, input logic [31:0] imm);
    req_valid = 1'b1; req_kind = kind; req_funct3 = f3;
    req_rs1 = rs1; req_rs2 = rs2; req_pc = pc; req_imm = imm;
    step();
    req_valid = 1'b0;
    check("eval_req_ready", req_ready, 0);
    check("eval_busy", busy, 1);
    check("eval_done_valid", done_valid, 0);
    step();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!req_ready && n < 40) begin
      step();
      n++;
    end
    check(tag, req_ready, 1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_kind = 2'b00; req_funct3 = 3'b000;
    req_rs1 = '0; req_rs2 = '0; req_pc = '0; req_imm = '0; redirect_ready = 1'b0;
`ifdef BRANCH_CTRL_STATS_EN
    stat_clr = 1'b0;
`endif
    step(); step();
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_flush", flush, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_link_data", link_data, 0);
    rst = 1'b0;
    step();

    // beq taken, redirect accepted immediately, 2 flush cycles
    redirect_ready = 1'b1;
    issue(KIND_BR, F3_BEQ, 32'h5, 32'h5, 32'h100, 32'h20);
    check("beq_done_valid", done_valid, 1);
    check("beq_taken", done_taken, 1);
    check("beq_redirect_pc", redirect_pc, 32'h120);
    check("beq_redirect_valid", redirect_valid, 1);
    check("beq_link", link_data, 0);
    check("beq_misalign", misalign, 0);
    check("beq_flush_t2", flush, 0);
    step();
    check("beq_flush_t3", flush, 1);
    check("beq_rv_t3", redirect_valid, 0);
    check("beq_dv_t3", done_valid, 0);
    step();
    check("beq_flush_t4", flush, 1);
    check("beq_ready_t4", req_ready, 0);
    step();
    check("beq_flush_t5", flush, 0);
    check("beq_ready_t5", req_ready, 1);
    check("beq_busy_t5", busy, 0);

    // bltu -1 < 1 unsigned: not taken
    issue(KIND_BR, F3_BLTU, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h8);
    check("bltu_done_valid", done_valid, 1);
    check("bltu_taken", done_taken, 0);
    check("bltu_rv", redirect_valid, 0);
    step();
    check("bltu_ready_t3", req_ready, 1);
    check("bltu_flush_t3", flush, 0);
    check("bltu_rv_t3", redirect_valid, 0);

    // blt -1 < 1 signed: taken
    issue(KIND_BR, F3_BLT, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h8);
    check("blt_taken", done_taken, 1);
    check("blt_redirect_pc", redirect_pc, 32'h208);
    check("blt_rv", redirect_valid, 1);
    wait_idle("blt_idle");

    // undefined funct3 with equal operands, and reserved kind: not taken
    issue(KIND_BR, 3'b010, 32'h7, 32'h7, 32'h0, 32'h4);
    check("f3_010_taken", done_taken, 0);
    step();
    check("f3_010_ready", req_ready, 1);
    issue(2'b11, F3_BEQ, 32'h7, 32'h7, 32'h0, 32'h4);
    check("kind11_taken", done_taken, 0);
    check("kind11_link", link_data, 0);
    step();

    // jalr misaligned target: reported, no redirect, no flush
    issue(KIND_JALR, 3'b000, 32'h1003, 32'h0, 32'h40, 32'h0);
    check("jalr_taken", done_taken, 1);
    check("jalr_redirect_pc", redirect_pc, 32'h1002);
    check("jalr_link", link_data, 32'h44);
    check("jalr_misalign", misalign, 1);
    check("jalr_rv", redirect_valid, 0);
    step();
    check("jalr_rv_t3", redirect_valid, 0);
    check("jalr_flush_t3", flush, 0);
    check("jalr_ready_t3", req_ready, 1);

    // jal with wrapping target, fetch stalls 3 cycles, req_valid held high
    redirect_ready = 1'b0;
    req_valid = 1'b1; req_kind = KIND_JAL; req_funct3 = 3'b000;
    req_rs1 = '0; req_rs2 = '0; req_pc = 32'hFFFFFFF0; req_imm = 32'h20;
    step();
    check("jal_ready_t1", req_ready, 0);
    step();
    check("jal_done_valid", done_valid, 1);
    check("jal_rv_t2", redirect_valid, 1);
    check("jal_redirect_pc", redirect_pc, 32'h10);
    check("jal_link", link_data, 32'hFFFFFFF4);
    check("jal_misalign", misalign, 0);
    step();
    check("jal_rv_t3", redirect_valid, 1);
    check("jal_pc_t3", redirect_pc, 32'h10);
    check("jal_flush_t3", flush, 0);
    check("jal_dv_t3", done_valid, 0);
    step();
    check("jal_rv_t4", redirect_valid, 1);
    check("jal_ready_t4", req_ready, 0);
    step();
    check("jal_rv_t5", redirect_valid, 1);
    check("jal_pc_t5", redirect_pc, 32'h10);
    redirect_ready = 1'b1;
    step();
    check("jal_flush_t6", flush, 1);
    check("jal_rv_t6", redirect_valid, 0);
    check("jal_ready_t6", req_ready, 0);
    step();
    check("jal_flush_t7", flush, 1);
    step();
    check("jal_flush_t8", flush, 0);
    check("jal_ready_t8", req_ready, 1);
    step();
    check("jal2_accepted_busy", busy, 1);
    check("jal2_accepted_ready", req_ready, 0);
    req_valid = 1'b0;
    step();
    check("jal2_done_valid", done_valid, 1);
    step();
    check("jal2_flush", flush, 1);

    // asynchronous reset in the middle of the flush
    rst = 1'b1;
    #1;
    check("mid_rst_flush", flush, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rv", redirect_valid, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_redirect_pc", redirect_pc, 0);
    step();
    rst = 1'b0;
    step();
    issue(KIND_BR, F3_BGE, 32'h3, 32'h3, 32'h300, 32'hFFFFFFFC);
    check("bge_taken", done_taken, 1);
    check("bge_redirect_pc", redirect_pc, 32'h2FC);
    check("bge_rv", redirect_valid, 1);
    wait_idle("bge_idle");

`ifdef BRANCH_CTRL_STATS_EN
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("stat_clr_total", stat_total, 0);
    check("stat_clr_taken", stat_taken, 0);
    for (int i = 0; i < 3; i++) begin
      issue(KIND_JAL, 3'b000, 32'h0, 32'h0, 32'h1000, 32'h40);
      wait_idle("stat_jal_idle");
    end
    for (int i = 0; i < 2; i++) begin
      issue(KIND_BR, F3_BNE, 32'h9, 32'h9, 32'h1000, 32'h40);
      wait_idle("stat_bne_idle");
    end
    check("stat_total_5", stat_total, 5);
    check("stat_taken_3", stat_taken, 3);
    issue(KIND_JAL, 3'b000, 32'h0, 32'h0, 32'h1000, 32'h40);
    check("stat_coinc_dv", done_valid, 1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("stat_coinc_total", stat_total, 0);
    check("stat_coinc_taken", stat_taken, 0);
    wait_idle("stat_coinc_idle");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
